// File: rtl/fractran_sequencer.sv
// FRACTRAN program store and fraction scheduler: issues prog[idx] over valid/ready and walks the list on dp_done results.
// Optional step budget is enabled by defining FRACTRAN_STEP_LIMIT_EN.
module fractran_sequencer #(
  parameter int NFRAC      = 8,
  parameter int IW         = $clog2(NFRAC),
  parameter int SW         = 16,
  parameter int STEP_LIMIT = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          prog_we,
  input  logic [IW-1:0] prog_addr,
  input  logic [7:0]    prog_data,
  input  logic [IW:0]   prog_len,
  input  logic          start,
  input  logic          abort,
  output logic [7:0]    frac,
  output logic          frac_valid,
  input  logic          frac_ready,
  input  logic          dp_done,
  input  logic          dp_hit,
  output logic          busy,
  output logic          halted,
  output logic          limit_hit,
  output logic [IW-1:0] frac_idx,
  output logic [SW-1:0] step_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALT} state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [IW:0]   len_reg, len_next;
  logic [SW-1:0] step_reg, step_next;
  logic [SW-1:0] step_inc;
  logic          len_ok;
  logic          prog_wr;
  logic [7:0]    prog_view [NFRAC];

`ifdef FRACTRAN_STEP_LIMIT_EN
  logic limit_reg, limit_next;
  logic limit_reached;
  assign limit_reached = (step_inc == SW'(STEP_LIMIT));
  assign limit_hit     = limit_reg;
`else
  assign limit_hit = 1'b0;
`endif

  assign step_inc = (&step_reg) ? step_reg : step_reg + 1'b1;
  assign len_ok   = (prog_len != '0) && (prog_len <= (IW+1)'(NFRAC));
  assign prog_wr  = en && prog_we && (state_reg == IDLE || state_reg == HALT);

  // One register per slot so reset can clear the whole program at once.
  for (genvar gi = 0; gi < NFRAC; gi++) begin : g_slot
    logic [7:0] slot_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        slot_reg <= '0;
      end else if (prog_wr && prog_addr == IW'(gi)) begin
        slot_reg <= prog_data;
      end
    end
    assign prog_view[gi] = slot_reg;
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    len_next   = len_reg;
    step_next  = step_reg;
`ifdef FRACTRAN_STEP_LIMIT_EN
    limit_next = limit_reg;
`endif
    if (abort) begin
      state_next = IDLE;
      idx_next   = '0;
    end else begin
      case (state_reg)
        IDLE, HALT: begin
          if (start) begin
            step_next = '0;
            if (len_ok) begin
              len_next   = prog_len;
              idx_next   = '0;
              state_next = ISSUE;
`ifdef FRACTRAN_STEP_LIMIT_EN
              limit_next = 1'b0;
`endif
            end else begin
              state_next = HALT;
            end
          end
        end
        ISSUE: begin
          if (frac_ready) state_next = WAIT;
        end
        WAIT: begin
          if (dp_done) begin
            if (dp_hit) begin
              step_next  = step_inc;
              idx_next   = '0;
              state_next = ISSUE;
`ifdef FRACTRAN_STEP_LIMIT_EN
              if (limit_reached) begin
                state_next = HALT;
                limit_next = 1'b1;
              end
`endif
            end else if ({1'b0, idx_reg} == len_reg - 1'b1) begin
              state_next = HALT;
            end else begin
              idx_next   = idx_reg + 1'b1;
              state_next = ISSUE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      len_reg   <= '0;
      step_reg  <= '0;
`ifdef FRACTRAN_STEP_LIMIT_EN
      limit_reg <= 1'b0;
`endif
    end else if (en) begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      len_reg   <= len_next;
      step_reg  <= step_next;
`ifdef FRACTRAN_STEP_LIMIT_EN
      limit_reg <= limit_next;
`endif
    end
  end

  assign frac       = prog_view[idx_reg];
  assign frac_valid = (state_reg == ISSUE);
  assign busy       = (state_reg == ISSUE) || (state_reg == WAIT);
  assign halted     = (state_reg == HALT);
  assign frac_idx   = idx_reg;
  assign step_count = step_reg;

endmodule

// File: tb/tb_fractran_sequencer.sv
// Testbench for fractran_sequencer: directed vector table, corner sequences, and random FRACTRAN runs
// checked against a behavioural first-applicable-fraction model.
module tb_fractran_sequencer;
  localparam int NFRAC = 8;
  localparam int IW = 3;
  localparam int SW = 16;
  localparam int STEP_LIMIT = 3;
  localparam int MAXTRY = 40;

  logic clk = 1'b0;
  logic rst, en, prog_we, start, abort, frac_ready, dp_done, dp_hit;
  logic [IW-1:0] prog_addr;
  logic [7:0] prog_data;
  logic [IW:0] prog_len;
  logic [7:0] frac;
  logic frac_valid, busy, halted, limit_hit;
  logic [IW-1:0] frac_idx;
  logic [SW-1:0] step_count;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fractran_sequencer #(.NFRAC(NFRAC), .IW(IW), .SW(SW), .STEP_LIMIT(STEP_LIMIT)) dut (
    .clk(clk), .rst(rst), .en(en), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start), .abort(abort),
    .frac(frac), .frac_valid(frac_valid), .frac_ready(frac_ready), .dp_done(dp_done),
    .dp_hit(dp_hit), .busy(busy), .halted(halted), .limit_hit(limit_hit),
    .frac_idx(frac_idx), .step_count(step_count)
  );

  typedef struct packed {
    logic [4:0]    in;   // en, start, frac_ready, dp_done, dp_hit
    logic [2:0]    st;   // frac_valid, busy, halted
    logic [7:0]    fr;
    logic [IW-1:0] idx;
    logic [SW-1:0] sc;
  } vec_t;

  vec_t tbl [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    en = 1'b1; prog_we = 1'b0; start = 1'b0; abort = 1'b0;
    frac_ready = 1'b0; dp_done = 1'b0; dp_hit = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input int addr, input logic [7:0] data);
    prog_we = 1'b1; prog_addr = IW'(addr); prog_data = data;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic do_result(input logic hit);
    frac_ready = 1'b1; tick(); frac_ready = 1'b0;
    dp_done = 1'b1; dp_hit = hit; tick(); dp_done = 1'b0; dp_hit = 1'b0;
  endtask

  task automatic run_random(input int r);
    logic [7:0] pg [NFRAC];
    logic [7:0] exp_q [$];
    logic [7:0] cur;
    logic [3:0] den;
    int len, hits, i, n0;
    bit halt_nat, lim, found;
    longint unsigned n, acc;

    abort = 1'b1; tick(); abort = 1'b0;
    for (int s = 0; s < NFRAC; s++) begin
      pg[s] = {4'($urandom_range(1, 15)), 4'($urandom_range(1, 15))};
      wr(s, pg[s]);
    end
    len = $urandom_range(1, NFRAC);
    n0 = $urandom_range(1, 5000);

    // Reference: each step tries fractions in order and applies the first whose denominator divides n.
    exp_q.delete();
    n = longint'(n0); hits = 0; halt_nat = 0; lim = 0;
    while (!halt_nat && !lim && exp_q.size() < MAXTRY) begin
      found = 0;
      for (i = 0; i < len; i++) begin
        if (exp_q.size() >= MAXTRY) break;
        exp_q.push_back(pg[i]);
        if (n % longint'(pg[i][3:0]) == 0) begin
          n = n / longint'(pg[i][3:0]) * longint'(pg[i][7:4]);
          hits++;
          found = 1;
          break;
        end
      end
      if (!found && i == len) halt_nat = 1;
`ifdef FRACTRAN_STEP_LIMIT_EN
      if (found && hits == STEP_LIMIT) lim = 1;
`endif
    end

    prog_len = (IW+1)'(len);
    start = 1'b1; tick(); start = 1'b0;
    acc = longint'(n0);
    for (int k = 0; k < exp_q.size(); k++) begin
      check("rand_issue", {frac_valid, frac}, {1'b1, exp_q[k]});
      repeat ($urandom_range(0, 2)) tick();
      frac_ready = 1'b1; cur = frac; tick(); frac_ready = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      den = cur[3:0];
      dp_hit = (den != 0) && (acc % longint'(den) == 0);
      if (dp_hit) acc = acc / longint'(den) * longint'(cur[7:4]);
      dp_done = 1'b1; tick(); dp_done = 1'b0; dp_hit = 1'b0;
    end
    if (halt_nat) begin
      check("rand_halt", {halted, frac_idx, step_count}, {1'b1, IW'(len - 1), SW'(hits)});
    end else if (lim) begin
      check("rand_limit", {halted, limit_hit, step_count}, {1'b1, 1'b1, SW'(hits)});
    end else begin
      check("rand_running", {busy, step_count}, {1'b1, SW'(hits)});
      abort = 1'b1; tick(); abort = 1'b0;
      check("rand_abort", {busy, step_count}, {1'b0, SW'(hits)});
    end
    $display("run %0d: len=%0d n0=%0d attempts=%0d hits=%0d halt=%0b limit=%0b",
             r, len, n0, exp_q.size(), hits, halt_nat, lim);
  endtask

  initial begin
    tbl[0]  = '{5'b11000, 3'b110, 8'h32, 3'd0, 16'd0};
    tbl[1]  = '{5'b10011, 3'b110, 8'h32, 3'd0, 16'd0};
    tbl[2]  = '{5'b10100, 3'b010, 8'h32, 3'd0, 16'd0};
    tbl[3]  = '{5'b00011, 3'b010, 8'h32, 3'd0, 16'd0};
    tbl[4]  = '{5'b11000, 3'b010, 8'h32, 3'd0, 16'd0};
    tbl[5]  = '{5'b10010, 3'b110, 8'h53, 3'd1, 16'd0};
    tbl[6]  = '{5'b10100, 3'b010, 8'h53, 3'd1, 16'd0};
    tbl[7]  = '{5'b10011, 3'b110, 8'h32, 3'd0, 16'd1};
    tbl[8]  = '{5'b10100, 3'b010, 8'h32, 3'd0, 16'd1};
    tbl[9]  = '{5'b10010, 3'b110, 8'h53, 3'd1, 16'd1};
    tbl[10] = '{5'b10100, 3'b010, 8'h53, 3'd1, 16'd1};
    tbl[11] = '{5'b10010, 3'b001, 8'h53, 3'd1, 16'd1};
    tbl[12] = '{5'b10011, 3'b001, 8'h53, 3'd1, 16'd1};

    clear_in();
    rst = 1'b1; prog_addr = '0; prog_data = '0; prog_len = '0;
    repeat (2) tick();
    check("reset_outputs", {frac, frac_valid, busy, halted, limit_hit, frac_idx, step_count}, 64'd0);
    rst = 1'b0;
    tick();

    // Directed program: 3/2, 5/3
    wr(0, 8'h32);
    wr(1, 8'h53);
    prog_len = 4'd2;
    for (int v = 0; v < 13; v++) begin
      {en, start, frac_ready, dp_done, dp_hit} = tbl[v].in;
      tick();
      clear_in();
      check("vector", {frac_valid, busy, halted, frac, frac_idx, step_count},
            {tbl[v].st, tbl[v].fr, tbl[v].idx, tbl[v].sc});
      $display("vec %0d: in=%b valid=%b busy=%b halted=%b frac=%h idx=%0d steps=%0d",
               v, tbl[v].in, frac_valid, busy, halted, frac, frac_idx, step_count);
    end

    // frac held stable while the datapath stalls
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("stall_stable", {frac_valid, frac}, {1'b1, 8'h32});
    end
    frac_ready = 1'b1; tick(); frac_ready = 1'b0;
    check("stall_to_wait", {frac_valid, busy}, {1'b0, 1'b1});

    // abort beats a coincident hit
    dp_done = 1'b1; dp_hit = 1'b1; tick(); dp_done = 1'b0; dp_hit = 1'b0;
    do_result(1'b1);
    frac_ready = 1'b1; tick(); frac_ready = 1'b0;
    check("pre_abort", {busy, frac_valid, step_count}, {1'b1, 1'b0, 16'd2});
    abort = 1'b1; dp_done = 1'b1; dp_hit = 1'b1; tick(); clear_in();
    check("abort_wait", {busy, halted, frac_valid, frac_idx, step_count}, {1'b0, 1'b0, 1'b0, 3'd0, 16'd2});

    // out-of-range lengths halt immediately and clear the step count
    prog_len = 4'd0; start = 1'b1; tick(); start = 1'b0;
    check("len_zero", {halted, busy, step_count}, {1'b1, 1'b0, 16'd0});
    prog_len = 4'd9; start = 1'b1; tick(); start = 1'b0;
    check("len_over", {halted, busy, step_count}, {1'b1, 1'b0, 16'd0});

    // program writes while running are dropped; writes in HALT land, even with start
    prog_len = 4'd2; start = 1'b1; tick(); start = 1'b0;
    prog_we = 1'b1; prog_addr = 3'd0; prog_data = 8'h77; tick(); prog_we = 1'b0;
    check("we_in_issue", {frac_valid, frac}, {1'b1, 8'h32});
    do_result(1'b0);
    do_result(1'b0);
    check("we_halt", halted, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    check("we_dropped", {frac_valid, frac}, {1'b1, 8'h32});
    do_result(1'b0);
    do_result(1'b0);
    prog_we = 1'b1; prog_addr = 3'd0; prog_data = 8'h77; start = 1'b1; tick(); clear_in();
    check("we_with_start", {frac_valid, frac}, {1'b1, 8'h77});

    // reset mid-run in WAIT
    do_result(1'b1);
    do_result(1'b1);
    frac_ready = 1'b1; tick(); frac_ready = 1'b0;
    check("pre_reset", {busy, frac_valid, step_count}, {1'b1, 1'b0, 16'd2});
    rst = 1'b1; #1;
    check("reset_async", {frac, frac_valid, busy, halted, limit_hit, frac_idx, step_count}, 64'd0);
    tick(); rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("reset_prog0", {frac_valid, frac}, {1'b1, 8'h00});
    do_result(1'b0);
    check("reset_prog1", {frac_valid, frac, frac_idx}, {1'b1, 8'h00, 3'd1});
    abort = 1'b1; tick(); abort = 1'b0;

    // step budget with an always-hitting datapath
    wr(0, 8'h11);
    prog_len = 4'd1; start = 1'b1; tick(); start = 1'b0;
    repeat (3) do_result(1'b1);
`ifdef FRACTRAN_STEP_LIMIT_EN
    check("limit_halt", {halted, busy, limit_hit, step_count}, {1'b1, 1'b0, 1'b1, 16'd3});
`else
    check("nolimit_run", {busy, halted, limit_hit, step_count}, {1'b1, 1'b0, 1'b0, 16'd3});
    repeat (2) do_result(1'b1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("nolimit_abort", {busy, halted, limit_hit, step_count}, {1'b0, 1'b0, 1'b0, 16'd5});
`endif

    for (int r = 0; r < 25; r++) run_random(r);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
